fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000060, PC loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_read  output  1  instruction-memory read request.
REQ-005 imem_address  output  32  fetch address; always equals the PC register.
REQ-006 imem_rdata  input  32  instruction word; valid only when imem_resp=1.
REQ-007 imem_resp  input  1  memory response; may arrive in the same cycle as the request.
REQ-008 stall  input  1  decode cannot accept; IF/ID register must hold.
REQ-009 redirect  input  1  taken branch/jump from execute; flush and refetch.
REQ-010 redirect_pc  input  32  target PC, valid when redirect=1.
REQ-011 id_instr  output  32  IF/ID instruction word, drives decode.
REQ-012 id_pc  output  32  PC of id_instr.
REQ-013 id_false_nop  output  1  1 = id_instr is an inserted bubble; decode must not emit control.

Function
REQ-014 The FSM SHALL have states S_REQ (request outstanding), S_HOLD (response buffered under stall) and S_DRAIN (discarding a stale response).
REQ-015 imem_read SHALL be 1 in S_REQ and S_DRAIN, 0 in S_HOLD, and 0 while rst=1.
REQ-016 S_REQ, imem_resp=1, stall=0, redirect=0: IF/ID SHALL load {imem_rdata, pc, false_nop=0} and pc SHALL become pc+4 (mod 2^32); remain S_REQ.
REQ-017 S_REQ, imem_resp=1, stall=1, redirect=0: the response SHALL be captured in a hold buffer, the PC held, next state S_HOLD.
REQ-018 S_HOLD, stall=0, redirect=0: IF/ID SHALL load the buffered word and its PC, pc SHALL become pc+4, next state S_REQ.
REQ-019 S_REQ, imem_resp=0, stall=0: IF/ID SHALL load a bubble (id_instr=32'h00000013, id_false_nop=1).
REQ-020 stall=1 and redirect=0: IF/ID SHALL hold its contents unchanged.
REQ-021 redirect=1 SHALL take priority over stall; IF/ID SHALL load a bubble and pc SHALL become redirect_pc.
REQ-022 redirect=1 in S_REQ with imem_resp=0: next state S_DRAIN; imem_read stays asserted with imem_address=redirect_pc from the next cycle.
REQ-023 S_DRAIN: imem_read SHALL remain 1 until imem_resp; that response SHALL be discarded; next state S_REQ.
REQ-024 redirect=1 in S_REQ with imem_resp=1, or in S_HOLD: the response or buffered word SHALL be discarded; next state S_REQ.
REQ-025 redirect=1 in S_DRAIN SHALL update pc to the new redirect_pc and remain in S_DRAIN.
REQ-026 With single-cycle memory, throughput SHALL be one instruction per cycle, with id_instr valid one cycle after the request.
REQ-027 No response SHALL ever reach IF/ID with id_false_nop=0 when it was fetched from a pre-redirect PC.

Reset
REQ-028 On rst=1: pc=RESET_PC, state=S_REQ, id_instr=32'h00000013, id_pc=0, id_false_nop=1, hold buffer cleared.
REQ-029 rst SHALL override every other input, including a mid-drain response.
REQ-030 After reset, no response to a request issued before reset SHALL be forwarded to IF/ID.

Configuration
REQ-031 Macro FETCH_PERF_COUNTERS_EN, when defined, SHALL add outputs perf_fetched[31:0] and perf_bubbles[31:0].
REQ-032 perf_fetched SHALL count IF/ID loads with id_false_nop=0, and perf_bubbles SHALL count bubble loads.
REQ-033 Both counters SHALL reset to 0 on rst and wrap at 2^32.
REQ-034 Without the macro, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-035 Shared package rv32i_types SHALL hold fetch_state_t (S_REQ, S_HOLD, S_DRAIN) and the constant NOP_INSTR = 32'h00000013.
REQ-036 The IF/ID register SHALL be a sub-module ifid_reg with load, flush and hold controls; the FSM and PC live in fetch_unit.

Verification
REQ-037 Reset, single-cycle memory returning 32'h00A00093 at 0x60 -> cycle 1 after reset: id_instr=32'h00A00093, id_pc=0x60, id_false_nop=0; imem_address=0x64.
REQ-038 Resp at 0x64 with stall=1 for 3 cycles -> IF/ID held, imem_read=0 during S_HOLD; on stall release id_pc=0x64, then imem_address=0x68.
REQ-039 Memory with 4-cycle latency, redirect to 0x200 in cycle 2 -> stale 0x68 word discarded; next valid id_pc=0x200; bubbles meanwhile.
REQ-040 redirect=1 and stall=1 in the same cycle -> id_false_nop=1 next cycle and pc=redirect_pc.
REQ-041 rst asserted in S_DRAIN -> state S_REQ, pc=0x60, id_false_nop=1; late response not forwarded.
REQ-042 With FETCH_PERF_COUNTERS_EN, 10 fetches plus 3 bubbles -> perf_fetched=10, perf_bubbles=3; both 0 after rst.

Source files
------------

// File: rtl/rv32i_types.sv
// -----------------------------------------------------------------------------
// rv32i_types -- shared types and constants for the RV32I front end.
//   fetch_state_t : fetch FSM states (S_REQ, S_HOLD, S_DRAIN)
//   NOP_INSTR     : canonical bubble (addi x0, x0, 0)
//   pc_plus4      : sequential PC increment, wraps modulo 2^32
// -----------------------------------------------------------------------------
package rv32i_types;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// -----------------------------------------------------------------------------
// ifid_reg -- IF/ID pipeline register.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   load_i          : capture instr_i/pc_i as a real instruction
//   flush_i         : insert a bubble (highest priority after reset)
//   hold_i          : keep current contents
//   instr_i, pc_i   : incoming instruction word and its PC
//   instr_o, pc_o   : register contents toward decode
//   false_nop_o     : 1 when instr_o is an inserted bubble
// Priority: rst > flush > hold > load; with no control asserted a bubble is
// inserted so the register never re-presents stale data.
// -----------------------------------------------------------------------------
module ifid_reg
   import rv32i_types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        flush_i,
   input  logic        hold_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        false_nop_o
);

   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic        false_nop_q;

   // IF/ID state update
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q     <= NOP_INSTR;
         pc_q        <= 32'd0;
         false_nop_q <= 1'b1;
      end else if (flush_i) begin
         instr_q     <= NOP_INSTR;
         pc_q        <= pc_i;
         false_nop_q <= 1'b1;
      end else if (hold_i) begin
         instr_q     <= instr_q;
         pc_q        <= pc_q;
         false_nop_q <= false_nop_q;
      end else if (load_i) begin
         instr_q     <= instr_i;
         pc_q        <= pc_i;
         false_nop_q <= 1'b0;
      end else begin
         instr_q     <= NOP_INSTR;
         pc_q        <= pc_i;
         false_nop_q <= 1'b1;
      end
   end

   assign instr_o     = instr_q;
   assign pc_o        = pc_q;
   assign false_nop_o = false_nop_q;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage: PC, fetch FSM and IF/ID register.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   imem_read          : instruction-memory read request (level)
//   imem_address       : fetch address, always the PC register
//   imem_rdata/resp    : memory response (may arrive in the request cycle)
//   stall              : decode cannot accept, IF/ID holds
//   redirect/_pc       : taken branch/jump, flush and refetch from redirect_pc
//   id_instr/id_pc     : IF/ID contents toward decode
//   id_false_nop       : 1 = id_instr is an inserted bubble
//   perf_fetched/_bubbles : IF/ID load counters, only when the macro
//                        FETCH_PERF_COUNTERS_EN is defined
// States: S_REQ   request outstanding at the PC
//         S_HOLD  response buffered while decode stalls (no request)
//         S_DRAIN request to a pre-redirect PC still in flight; its response
//                 is thrown away before refetching at the new PC
// -----------------------------------------------------------------------------
module fetch_unit
   import rv32i_types::*;
#(
   parameter logic [31:0] RESET_PC = 32'h00000060
)
(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_read,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_rdata,
   input  logic        imem_resp,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        id_false_nop
`ifdef FETCH_PERF_COUNTERS_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles
`endif
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  hold_q, hold_d;
   logic         imem_read_q;

   logic         ifid_load;
   logic         ifid_flush;
   logic         ifid_hold;
   logic [31:0]  ifid_instr;

   // Next-state, PC and IF/ID control decisions
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      hold_d     = hold_q;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      ifid_hold  = 1'b0;
      ifid_instr = imem_rdata;
      case (state_q)
         S_REQ: begin
            if (redirect) begin
               // Whatever arrives this cycle belongs to the old path.
               ifid_flush = 1'b1;
               pc_d       = redirect_pc;
               if (imem_resp) begin
                  state_d = S_REQ;
               end else begin
                  state_d = S_DRAIN;
               end
            end else if (imem_resp) begin
               if (stall) begin
                  ifid_hold = 1'b1;
                  hold_d    = imem_rdata;
                  state_d   = S_HOLD;
               end else begin
                  ifid_load = 1'b1;
                  pc_d      = pc_plus4(pc_q);
               end
            end else if (stall) begin
               ifid_hold = 1'b1;
            end else begin
               ifid_flush = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               ifid_flush = 1'b1;
               pc_d       = redirect_pc;
               hold_d     = 32'd0;
               state_d    = S_REQ;
            end else if (stall) begin
               ifid_hold = 1'b1;
            end else begin
               // The PC was frozen while holding, so it is the buffered word's PC.
               ifid_load  = 1'b1;
               ifid_instr = hold_q;
               pc_d       = pc_plus4(pc_q);
               state_d    = S_REQ;
            end
         end
         S_DRAIN: begin
            if (redirect) begin
               ifid_flush = 1'b1;
               pc_d       = redirect_pc;
               state_d    = S_DRAIN;
            end else begin
               if (stall) begin
                  ifid_hold = 1'b1;
               end else begin
                  ifid_flush = 1'b1;
               end
               // The stale response is dropped; refetch at the current PC.
               if (imem_resp) begin
                  state_d = S_REQ;
               end else begin
                  state_d = S_DRAIN;
               end
            end
         end
         default: begin
            ifid_flush = 1'b1;
            pc_d       = RESET_PC;
            state_d    = S_REQ;
         end
      endcase
   end

   // Fetch FSM, PC, hold buffer and registered read request
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         hold_q      <= 32'd0;
         imem_read_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         hold_q      <= hold_d;
         imem_read_q <= (state_d != S_HOLD);
      end
   end

   // Reset gating drops any in-flight request so nothing from before reset
   // can come back as a valid response.
   assign imem_read    = imem_read_q & ~rst;
   assign imem_address = pc_q;

   ifid_reg u_ifid_reg (
      .clk         (clk),
      .rst         (rst),
      .load_i      (ifid_load),
      .flush_i     (ifid_flush),
      .hold_i      (ifid_hold),
      .instr_i     (ifid_instr),
      .pc_i        (pc_q),
      .instr_o     (id_instr),
      .pc_o        (id_pc),
      .false_nop_o (id_false_nop)
   );

`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] perf_fetched_q;
   logic [31:0] perf_bubbles_q;

   // IF/ID load counters, wrap naturally at 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q <= 32'd0;
         perf_bubbles_q <= 32'd0;
      end else begin
         perf_fetched_q <= perf_fetched_q + {31'd0, ifid_load};
         perf_bubbles_q <= perf_bubbles_q + {31'd0, ifid_flush};
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- directed bench for fetch_unit with a behavioural memory of
// configurable latency (0 = response in the request cycle).
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_read;
   logic [31:0] imem_address;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_false_nop;
`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_bubbles;
`endif

   int total = 0;
   int bad   = 0;

   // memory model state
   int          lat = 0;
   logic        busy = 1'b0;
   int          cnt = 0;
   logic [31:0] lat_addr = 32'd0;

   fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .imem_read    (imem_read),
      .imem_address (imem_address),
      .imem_rdata   (imem_rdata),
      .imem_resp    (imem_resp),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .id_instr     (id_instr),
      .id_pc        (id_pc),
      .id_false_nop (id_false_nop)
`ifdef FETCH_PERF_COUNTERS_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_bubbles (perf_bubbles)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h00000060) return 32'h00A00093;
      else return {a[23:0], 8'h93};
   endfunction

   // memory response: combinational for latency 0, else from the latched address
   always_comb begin
      imem_resp  = 1'b0;
      imem_rdata = 32'hDEADBEEF;
      if (lat == 0) begin
         imem_resp = imem_read;
         if (imem_read) imem_rdata = memf(imem_address);
      end else if (imem_read && busy && cnt >= lat) begin
         imem_resp  = 1'b1;
         imem_rdata = memf(lat_addr);
      end
   end

   // memory request tracking; dropping imem_read aborts the request
   always @(posedge clk) begin
      if (rst || !imem_read || lat == 0) begin
         busy <= 1'b0;
      end else if (!busy) begin
         busy     <= 1'b1;
         lat_addr <= imem_address;
         cnt      <= 1;
      end else if (cnt >= lat) begin
         busy <= 1'b0;
      end else begin
         cnt <= cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      #1;
      chk("read_in_rst", {31'd0, imem_read}, 32'd0);
      step();
      chk("rst_instr", id_instr, NOP);
      chk("rst_pc", id_pc, 32'd0);
      chk("rst_nop", {31'd0, id_false_nop}, 32'd1);
      chk("rst_addr", imem_address, 32'h60);
      rst = 1'b0;
   endtask

   // Step until a real instruction reaches IF/ID, then check it.
   task automatic wait_valid(input string name, input logic [31:0] exp_pc, input int budget);
      int n;
      n = 0;
      stall = 1'b0; redirect = 1'b0;
      do begin
         step();
         n++;
      end while (id_false_nop && n < budget);
      if (id_false_nop) begin
         total++; bad++;
         $display("FAIL %s timeout actual=no_valid expected_pc=%h", name, exp_pc);
      end else begin
         chk({name, "_pc"}, id_pc, exp_pc);
         chk({name, "_instr"}, id_instr, memf(exp_pc));
      end
   endtask

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic        chk_pc;
      logic        e_nop;
      logic [31:0] e_addr;
      logic        e_read;
   } vec_t;

   vec_t vecs[14];

   initial begin
      // single-cycle memory walk starting right after reset
      vecs[0]  = '{1'b0, 1'b0, 32'h0,        memf(32'h60),  32'h60,  1'b1, 1'b0, 32'h64,  1'b1};
      vecs[1]  = '{1'b1, 1'b0, 32'h0,        memf(32'h60),  32'h60,  1'b1, 1'b0, 32'h64,  1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0,        memf(32'h60),  32'h60,  1'b1, 1'b0, 32'h64,  1'b0};
      vecs[3]  = '{1'b1, 1'b0, 32'h0,        memf(32'h60),  32'h60,  1'b1, 1'b0, 32'h64,  1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0,        memf(32'h64),  32'h64,  1'b1, 1'b0, 32'h68,  1'b1};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,        memf(32'h68),  32'h68,  1'b1, 1'b0, 32'h6C,  1'b1};
      vecs[6]  = '{1'b0, 1'b1, 32'h100,      NOP,           32'h0,   1'b0, 1'b1, 32'h100, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,        memf(32'h100), 32'h100, 1'b1, 1'b0, 32'h104, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 32'h200,      NOP,           32'h0,   1'b0, 1'b1, 32'h200, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 32'h0,        NOP,           32'h0,   1'b0, 1'b1, 32'h200, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'h300,      NOP,           32'h0,   1'b0, 1'b1, 32'h300, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 32'h0,        memf(32'h300), 32'h300, 1'b1, 1'b0, 32'h304, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 32'hFFFFFFFC, NOP,           32'h0,   1'b0, 1'b1, 32'hFFFFFFFC, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 32'h0,        memf(32'hFFFFFFFC), 32'hFFFFFFFC, 1'b1, 1'b0, 32'h0, 1'b1};

      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      @(negedge clk);
      lat = 0;
      do_reset();
`ifdef FETCH_PERF_COUNTERS_EN
      chk("perf_fetched_rst", perf_fetched, 32'd0);
      chk("perf_bubbles_rst", perf_bubbles, 32'd0);
`endif

      for (int i = 0; i < 14; i++) begin
         stall       = vecs[i].stall;
         redirect    = vecs[i].redirect;
         redirect_pc = vecs[i].rpc;
         step();
         chk($sformatf("v%0d_instr", i), id_instr, vecs[i].e_instr);
         if (vecs[i].chk_pc) chk($sformatf("v%0d_pc", i), id_pc, vecs[i].e_pc);
         chk($sformatf("v%0d_nop", i), {31'd0, id_false_nop}, {31'd0, vecs[i].e_nop});
         chk($sformatf("v%0d_addr", i), imem_address, vecs[i].e_addr);
         chk($sformatf("v%0d_read", i), {31'd0, imem_read}, {31'd0, vecs[i].e_read});
      end
      stall = 1'b0; redirect = 1'b0;

      // 4-cycle memory: redirect while 0x68 is in flight, stale word dropped
      lat = 4;
      do_reset();
      wait_valid("lat_first", 32'h60, 20);
      wait_valid("lat_second", 32'h64, 20);
      step();
      redirect = 1'b1; redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      chk("drain_nop", {31'd0, id_false_nop}, 32'd1);
      chk("drain_addr", imem_address, 32'h200);
      chk("drain_read", {31'd0, imem_read}, 32'd1);
      wait_valid("after_drain", 32'h200, 30);

      // second redirect while draining retargets the PC
      step();
      redirect = 1'b1; redirect_pc = 32'h400;
      step();
      redirect_pc = 32'h480;
      step();
      redirect = 1'b0;
      chk("redrain_addr", imem_address, 32'h480);
      chk("redrain_read", {31'd0, imem_read}, 32'd1);
      wait_valid("after_redrain", 32'h480, 30);

      // reset in the middle of a drain
      step();
      redirect = 1'b1; redirect_pc = 32'h700;
      step();
      redirect = 1'b0;
      chk("pre_rst_addr", imem_address, 32'h700);
      do_reset();
      #1;
      chk("post_rst_read", {31'd0, imem_read}, 32'd1);
      wait_valid("post_rst", 32'h60, 20);

      // counter run: 10 fetches then 3 redirect bubbles, single-cycle memory
      lat = 0;
      do_reset();
      for (int i = 0; i < 10; i++) step();
      chk("run_pc", id_pc, 32'h60 + 32'd36);
      redirect = 1'b1; redirect_pc = 32'h500;
      for (int i = 0; i < 3; i++) step();
      redirect = 1'b0;
      chk("run_bubble", {31'd0, id_false_nop}, 32'd1);
`ifdef FETCH_PERF_COUNTERS_EN
      chk("perf_fetched", perf_fetched, 32'd10);
      chk("perf_bubbles", perf_bubbles, 32'd3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("perf_fetched_clr", perf_fetched, 32'd0);
      chk("perf_bubbles_clr", perf_bubbles, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
